// File: rtl/quad_encoder_frontend.sv
// Quadrature encoder front end: synchronise, debounce, decode steps into a
// wrapping position, and (with QUAD_VELOCITY_EN defined) measure windowed velocity.
module quad_encoder_frontend #(
    parameter int FILTER_LEN = 4,
    parameter int COUNT_W    = 16,
    parameter int VEL_WINDOW = 50000
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               enc_a_raw,
    input  logic               enc_b_raw,
    input  logic               clear_count,
    input  logic               err_clear,
    output logic [1:0]         encoder_out,
    output logic [COUNT_W-1:0] position,
    output logic [COUNT_W-1:0] velocity,
    output logic               vel_valid,
    output logic               step,
    output logic               dir,
    output logic               quad_err
);

    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        filt;
    logic [1:0]        prev;
    logic [FCNT_W-1:0] fcnt [2];
    logic              primed;

    logic is_fwd;
    logic is_rev;
    logic step_fwd;
    logic step_rev;
    logic new_err;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, whatever the statement order.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            fcnt  <= '{default: '0};
        end else begin
            sync1 <= {enc_b_raw, enc_a_raw};
            sync2 <= sync1;
            // A channel only follows its input after FILTER_LEN consecutive mismatches.
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FCNT_W'(1);
                end
            end
        end
    end

    assign encoder_out = filt;

    // NOTE: both decode outputs get a default before the case so no path
    // leaves them unassigned, which would otherwise infer latches.
    always_comb begin
        is_fwd = 1'b0;
        is_rev = 1'b0;
        case (prev)
            2'b00: begin is_fwd = (filt == 2'b01); is_rev = (filt == 2'b10); end
            2'b01: begin is_fwd = (filt == 2'b11); is_rev = (filt == 2'b00); end
            2'b11: begin is_fwd = (filt == 2'b10); is_rev = (filt == 2'b01); end
            default: begin is_fwd = (filt == 2'b00); is_rev = (filt == 2'b11); end
        endcase
    end

    // The first change after reset only establishes a reference state.
    assign step_fwd = primed & is_fwd;
    assign step_rev = primed & is_rev;
    assign new_err  = primed & (&(filt ^ prev));

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            prev     <= '0;
            primed   <= 1'b0;
            step     <= 1'b0;
            dir      <= 1'b0;
            position <= '0;
            quad_err <= 1'b0;
        end else begin
            prev <= filt;
            if (filt != prev) begin
                primed <= 1'b1;
            end
            step <= step_fwd | step_rev;
            if (step_fwd | step_rev) begin
                dir <= step_fwd;
            end
            if (clear_count) begin
                position <= '0;
            end else if (step_fwd) begin
                position <= position + COUNT_W'(1);
            end else if (step_rev) begin
                position <= position - COUNT_W'(1);
            end
            // A fresh error wins over a simultaneous clear.
            quad_err <= new_err | (quad_err & ~err_clear);
        end
    end

`ifdef QUAD_VELOCITY_EN
    localparam int WIN_W = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
    localparam logic [COUNT_W-1:0] S_MAX = {1'b0, {(COUNT_W-1){1'b1}}};
    localparam logic [COUNT_W-1:0] S_MIN = {1'b1, {(COUNT_W-1){1'b0}}};

    logic [WIN_W-1:0]   wcnt;
    logic [COUNT_W-1:0] acc;
    logic [COUNT_W:0]   sum_wide;
    logic [COUNT_W-1:0] acc_sat;

    // Sign-extended accumulate of the +1/-1/0 step delta, then clamp on overflow.
    always_comb begin
        sum_wide = {acc[COUNT_W-1], acc} + {{COUNT_W{step_rev}}, step_fwd | step_rev};
        acc_sat  = sum_wide[COUNT_W-1:0];
        if (sum_wide[COUNT_W] != sum_wide[COUNT_W-1]) begin
            acc_sat = sum_wide[COUNT_W] ? S_MIN : S_MAX;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wcnt      <= '0;
            acc       <= '0;
            velocity  <= '0;
            vel_valid <= 1'b0;
        end else if (wcnt == WIN_W'(VEL_WINDOW - 1)) begin
            wcnt      <= '0;
            acc       <= '0;
            velocity  <= acc_sat;
            vel_valid <= 1'b1;
        end else begin
            wcnt      <= wcnt + WIN_W'(1);
            acc       <= acc_sat;
            vel_valid <= 1'b0;
        end
    end
`else
    assign velocity  = '0;
    assign vel_valid = 1'b0;
`endif

endmodule
